q_shift_reg: RTL and testbench
==============================

Name: q_shift_reg

Overview:
Parametrised Q register for the sequential multiplier/divider datapath.
- Loads an operand, then shifts right (arithmetic, Booth style) or left (divider style) one bit per cycle.
- Keeps the Booth Q(-1) bit and a shift counter.
- Asserts done after WIDTH shifts so the control FSM can stop without an external counter.

Parameters:
WIDTH, 8, data width of the register in bits (minimum 2).
RESET_VAL, 0, value loaded into qout on reset (WIDTH bits).
CNT_W, $clog2(WIDTH+1), width of the shift counter (derived; do not override).

Ports:
clk  input  1  system clock, all state updates on posedge.
rst  input  1  synchronous reset, active-low: rst==0 at a posedge resets the block.
ldp  input  1  load strobe: capture din.
din  input  WIDTH  parallel load data (switches or ALU result).
shr  input  1  shift right one position this cycle.
shl  input  1  shift left one position this cycle.
sin  input  1  serial input bit, enters at MSB on shr and at LSB on shl.
qout  output  WIDTH  register contents.
q_m1  output  1  Booth Q(-1) bit: last bit shifted out of the LSB.
cnt  output  CNT_W  number of shifts performed since the last load or reset.
done  output  1  high when cnt==WIDTH.

Behaviour:
- Reset (rst==0 at posedge): qout=RESET_VAL, q_m1=0, cnt=0. done is therefore 0. Reset overrides every other input.
- Priority when rst==1: ldp > shr > shl > hold. Exactly one action per cycle.
- Load (ldp=1):
  - qout<=din, q_m1<=0, cnt<=0.
  - Takes effect on the next posedge; qout reflects din 1 cycle after the strobe.
  - Load is accepted even when done=1, and restarts the sequence.
- Shift right (shr=1, ldp=0, done=0):
  - qout<={sin, qout[WIDTH-1:1]}, q_m1<=qout[0], cnt<=cnt+1.
  - Arithmetic shift is obtained by driving sin=qout[WIDTH-1] (or the A-register LSB) externally; the block does not choose.
- Shift left (shl=1, shr=0, ldp=0, done=0):
  - qout<={qout[WIDTH-2:0], sin}, q_m1 unchanged, cnt<=cnt+1.
- shr and shl both high: shr wins, shl is ignored. Not an error.
- done=1 (cnt==WIDTH):
  - shr/shl are ignored; qout, q_m1 and cnt hold.
  - cnt saturates at WIDTH and never wraps.
- Hold (no strobe): all state unchanged.
- done is combinational from cnt: it rises in the same cycle cnt reaches WIDTH, i.e. the cycle after the WIDTH-th shift strobe.
- Reset mid-sequence: everything returns to reset values at that posedge. The next ldp starts a fresh sequence.
- The register has no initial-value initialisation. State is defined only by reset or load.
- qout is driven only from the single always_ff block. No continuous assignment to a registered signal.

Optional Feature:
QREG_ROTATE_EN
- Defined: shl rotates instead of shifting. qout<={qout[WIDTH-2:0], qout[WIDTH-1]} and sin is ignored on shl. Counter and done behave as for a normal shift. shr is unaffected.
- Not defined: shl is the plain shift with sin entering at the LSB, as specified above.

Test Plan:
1. rst=0 for 2 cycles with ldp=1, din=8'hFF -> qout=8'h00, q_m1=0, cnt=0, done=0 (reset beats load).
2. rst=1, ldp=1, din=8'hC3; next cycle shr=1, sin=1 -> after load qout=8'hC3. After the shift qout=8'hE1, q_m1=1, cnt=1.
3. Load 8'h81, then 8 cycles of shr with sin=0 -> cnt=8, done=1, qout=8'h00. A 9th shr leaves qout, q_m1 and cnt unchanged.
4. Load 8'h81, then shl=1, sin=0 -> qout=8'h02 (rotate off), or qout=8'h03 with QREG_ROTATE_EN defined. Both cases give cnt=1.
5. Load 8'h0F, then shr=shl=1 with sin=0 -> qout=8'h07, q_m1=1 (shr priority). Then ldp=1, din=8'hAA with shr=1 -> qout=8'hAA, cnt=0, q_m1=0 (ldp priority).
6. Load 8'h55, 3 shr cycles, then rst=0 for one cycle -> qout=RESET_VAL, cnt=0, done=0. Repeat with WIDTH=16, RESET_VAL=16'h1234: 16 shifts assert done, cnt is 5 bits wide and holds at 16.

Source files
------------

// File: rtl/q_shift_reg.sv
// Q register for the sequential multiplier/divider: load, Booth right shift, divider left shift.
// Optional macro QREG_ROTATE_EN turns the left shift into a left rotate (sin ignored on shl).
module q_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ldp,
    input  logic [WIDTH-1:0] din,
    input  logic             shr,
    input  logic             shl,
    input  logic             sin,
    output logic [WIDTH-1:0] qout,
    output logic             q_m1,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] qout_d;
    logic             q_m1_d;
    logic [CNT_W-1:0] cnt_d;
    logic             lsb_in;

`ifdef QREG_ROTATE_EN
    assign lsb_in = qout[WIDTH-1];
`else
    assign lsb_in = sin;
`endif

    assign done = (cnt == CNT_MAX);

    // Shift strobes are dropped once done so cnt saturates at WIDTH.
    always_comb begin
        qout_d = qout;
        q_m1_d = q_m1;
        cnt_d  = cnt;
        if (ldp) begin
            qout_d = din;
            q_m1_d = 1'b0;
            cnt_d  = '0;
        end else if (shr && !done) begin
            qout_d = {sin, qout[WIDTH-1:1]};
            q_m1_d = qout[0];
            cnt_d  = cnt + 1'b1;
        end else if (shl && !done) begin
            qout_d = {qout[WIDTH-2:0], lsb_in};
            cnt_d  = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            qout <= RESET_VAL;
            q_m1 <= 1'b0;
            cnt  <= '0;
        end else begin
            qout <= qout_d;
            q_m1 <= q_m1_d;
            cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_q_shift_reg.sv
// Bench for q_shift_reg: directed plan scenarios plus random stimulus vs. an arithmetic model.
// Two instances (WIDTH=8 and WIDTH=16/RESET_VAL=16'h1234) share the control inputs.
module tb_q_shift_reg;

    logic        clk;
    logic        rst, ldp, shr, shl, sin;
    logic [7:0]  din8;
    logic [15:0] din16;

    logic [7:0]  q8;
    logic        m8, d8;
    logic [3:0]  c8;
    logic [15:0] q16;
    logic        m16, d16;
    logic [4:0]  c16;

    int n_cmp = 0;
    int n_err = 0;

    int mq[2];
    int mm1[2];
    int mcnt[2];
    int W[2]  = '{8, 16};
    int RV[2] = '{0, 'h1234};

    q_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) u8 (
        .clk(clk), .rst(rst), .ldp(ldp), .din(din8),
        .shr(shr), .shl(shl), .sin(sin),
        .qout(q8), .q_m1(m8), .cnt(c8), .done(d8)
    );

    q_shift_reg #(.WIDTH(16), .RESET_VAL(16'h1234)) u16 (
        .clk(clk), .rst(rst), .ldp(ldp), .din(din16),
        .shr(shr), .shl(shl), .sin(sin),
        .qout(q16), .q_m1(m16), .cnt(c16), .done(d16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef QREG_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    // Reference: value-level rules, one call per clock edge.
    task automatic model_edge(input int i, input int d);
        int mask;
        int msb;
        mask = (1 << W[i]) - 1;
        if (!rst) begin
            mq[i] = RV[i]; mm1[i] = 0; mcnt[i] = 0;
        end else if (ldp) begin
            mq[i] = d & mask; mm1[i] = 0; mcnt[i] = 0;
        end else if (mcnt[i] < W[i] && shr) begin
            mm1[i] = mq[i] % 2;
            mq[i] = (mq[i] / 2) + (sin ? (1 << (W[i] - 1)) : 0);
            mcnt[i] = mcnt[i] + 1;
        end else if (mcnt[i] < W[i] && shl) begin
            msb = (mq[i] >> (W[i] - 1)) & 1;
            mq[i] = ((mq[i] * 2) & mask) + (ROT ? msb : int'(sin));
            mcnt[i] = mcnt[i] + 1;
        end
    endtask

    task automatic step(input bit r, input bit l, input int d,
                        input bit sr, input bit sl, input bit s);
        rst = r; ldp = l; shr = sr; shl = sl; sin = s;
        din8 = d[7:0]; din16 = d[15:0];
        @(posedge clk);
        model_edge(0, d & 'hFF);
        model_edge(1, d & 'hFFFF);
        #1;
    endtask

    task automatic test_reset();
        step(0, 1, 'hFF, 0, 0, 0);
        step(0, 1, 'hFF, 0, 0, 0);
        n_cmp++;
        if ({q8, m8, c8, d8} !== {8'h00, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset8 got q=%h m=%b c=%0d d=%b want 00/0/0/0", q8, m8, c8, d8);
        end
        n_cmp++;
        if ({q16, m16, c16, d16} !== {16'h1234, 1'b0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset16 got q=%h m=%b c=%0d d=%b want 1234/0/0/0", q16, m16, c16, d16);
        end
    endtask

    task automatic test_load_shift();
        step(1, 1, 'hC3, 0, 0, 0);
        n_cmp++;
        if (q8 !== 8'hC3) begin
            n_err++;
            $display("FAIL load got %h want c3", q8);
        end
        step(1, 0, 0, 1, 0, 1);
        n_cmp++;
        if ({q8, m8, c8} !== {8'hE1, 1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL shr1 got q=%h m=%b c=%0d want e1/1/1", q8, m8, c8);
        end
    endtask

    task automatic test_done();
        step(1, 1, 'h81, 0, 0, 0);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 1, 0, 0);
        n_cmp++;
        if ({q8, c8, d8} !== {8'h00, 4'd8, 1'b1}) begin
            n_err++;
            $display("FAIL done8 got q=%h c=%0d d=%b want 00/8/1", q8, c8, d8);
        end
        step(1, 0, 0, 1, 0, 1);
        n_cmp++;
        if ({q8, m8, c8, d8} !== {8'h00, 1'b1, 4'd8, 1'b1}) begin
            n_err++;
            $display("FAIL sat8 got q=%h m=%b c=%0d d=%b want 00/1/8/1", q8, m8, c8, d8);
        end
        // 16-bit instance: 16 shifts, then saturation
        step(1, 1, 'hBEEF, 0, 0, 0);
        for (int k = 0; k < 15; k++) step(1, 0, 0, 1, 0, 1);
        n_cmp++;
        if (d16 !== 1'b0 || c16 !== 5'd15) begin
            n_err++;
            $display("FAIL pre16 got c=%0d d=%b want 15/0", c16, d16);
        end
        step(1, 0, 0, 1, 0, 1);
        n_cmp++;
        if ({q16, c16, d16} !== {16'hFFFF, 5'd16, 1'b1}) begin
            n_err++;
            $display("FAIL done16 got q=%h c=%0d d=%b want ffff/16/1", q16, c16, d16);
        end
        step(1, 0, 0, 0, 1, 0);
        n_cmp++;
        if ({q16, c16, d16} !== {16'hFFFF, 5'd16, 1'b1}) begin
            n_err++;
            $display("FAIL sat16 got q=%h c=%0d d=%b want ffff/16/1", q16, c16, d16);
        end
    endtask

    task automatic test_shl();
        logic [7:0] want;
        want = ROT ? 8'h03 : 8'h02;
        step(1, 1, 'h81, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        n_cmp++;
        if ({q8, m8, c8} !== {want, 1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL shl got q=%h m=%b c=%0d want %h/0/1", q8, m8, c8, want);
        end
    endtask

    task automatic test_priority();
        step(1, 1, 'h0F, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0);
        n_cmp++;
        if ({q8, m8, c8} !== {8'h07, 1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL shr_pri got q=%h m=%b c=%0d want 07/1/1", q8, m8, c8);
        end
        step(1, 1, 'hAA, 1, 0, 0);
        n_cmp++;
        if ({q8, m8, c8} !== {8'hAA, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL ldp_pri got q=%h m=%b c=%0d want aa/0/0", q8, m8, c8);
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 'h55, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        n_cmp++;
        if ({q8, m8, c8, d8} !== {8'h00, 1'b0, 4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid8 got q=%h m=%b c=%0d d=%b", q8, m8, c8, d8);
        end
        n_cmp++;
        if ({q16, m16, c16, d16} !== {16'h1234, 1'b0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL rstmid16 got q=%h m=%b c=%0d d=%b", q16, m16, c16, d16);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 60) != 0, $urandom_range(0, 24) == 0,
                 int'($urandom & 'hFFFF), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            n_cmp++;
            if (q8 !== mq[0][7:0] || m8 !== mm1[0][0] || c8 !== mcnt[0][3:0] ||
                d8 !== (mcnt[0] == 8)) begin
                n_err++;
                $display("FAIL rand8 k=%0d got %h/%b/%0d/%b want %h/%0d/%0d",
                         k, q8, m8, c8, d8, mq[0], mm1[0], mcnt[0]);
            end
            n_cmp++;
            if (q16 !== mq[1][15:0] || m16 !== mm1[1][0] || c16 !== mcnt[1][4:0] ||
                d16 !== (mcnt[1] == 16)) begin
                n_err++;
                $display("FAIL rand16 k=%0d got %h/%b/%0d/%b want %h/%0d/%0d",
                         k, q16, m16, c16, d16, mq[1], mm1[1], mcnt[1]);
            end
        end
    endtask

    initial begin
        rst = 0; ldp = 0; shr = 0; shl = 0; sin = 0;
        din8 = '0; din16 = '0;
        #1;
        test_reset();
        test_load_shift();
        test_done();
        test_shl();
        test_priority();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
